// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: loads a WIDTH-bit word on valid/ready, shifts it out LSB first.
// Define PISO_PARITY_EN to append an even-parity bit after the MSB of every frame.
module piso_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_data;
  logic             last_bit;
  logic             accept;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
`endif

  assign last_data = (state_q == StShift) && (cnt_q == LastCnt);

`ifdef PISO_PARITY_EN
  assign last_bit = (state_q == StParity);
`else
  assign last_bit = last_data;
`endif

  // Ready during the final bit lets the next frame follow with no idle gap.
  assign load_ready = (state_q == StIdle) || last_bit;
  assign accept     = load_valid && load_ready;

  always_comb begin
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    done        = last_bit;
    unique case (state_q)
      StShift: begin
        sout        = sreg_q[0];
        sout_valid  = 1'b1;
        frame_start = (cnt_q == '0);
      end
`ifdef PISO_PARITY_EN
      StParity: begin
        sout       = par_q;
        sout_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StShift: begin
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (last_data) begin
`ifdef PISO_PARITY_EN
          state_d = StParity;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      StParity: state_d = StIdle;
`endif
      default: ;
    endcase
    if (accept) begin
      state_d = StShift;
      sreg_d  = din;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      par_d   = ^din;
`endif
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: accepted words become queued expected bits,
// a negedge monitor pops and compares them against the serial outputs.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         async_reset = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, sout, sout_valid, frame_start, done;

  int total = 0;
  int bad   = 0;

  // Each entry: {expected sout, expected frame_start, expected done}
  logic [2:0] exp_q[$];
  logic [2:0] e;
  logic       rdy_model;

  piso_serializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .async_reset (async_reset),
    .din         (din),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    int n;
`ifdef PISO_PARITY_EN
    n = W + 1;
`else
    n = W;
`endif
    for (int i = 0; i < W; i++) begin
      exp_q.push_back({w[i], (i == 0), (i == n - 1)});
    end
`ifdef PISO_PARITY_EN
    exp_q.push_back({^w, 1'b0, 1'b1});
`endif
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_sout"}, sout, 0);
    chk({nm, "_valid"}, sout_valid, 0);
    chk({nm, "_fstart"}, frame_start, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_ready"}, load_ready, 1);
  endtask

  // Monitor + reference model: ready is high exactly when at most the current bit remains.
  always @(negedge clk) begin
    if (!async_reset) begin
      exp_q.delete();
      chk_reset_outputs("rst_hold");
    end else begin
      rdy_model = (exp_q.size() <= 1);
      chk("load_ready", load_ready, rdy_model);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sout_valid", sout_valid, 1);
        chk("sout", sout, e[2]);
        chk("frame_start", frame_start, e[1]);
        chk("done", done, e[0]);
      end else begin
        chk("idle_outputs", {sout_valid, sout, frame_start, done}, 0);
      end
      if (load_valid && rdy_model) push_frame(din);
    end
  end

  task automatic send(input logic [W-1:0] w);
    bit ok = 0;
    din        = w;
    load_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (load_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk_reset_outputs("rst_init");
    @(posedge clk);
    #1;
    async_reset = 1'b1;

    // Single frame.
    send(8'hA5);
    idle(12);

    // Back-to-back frames.
    send(8'h0F);
    send(8'hF0);
    idle(12);

    // Busy-time changes to din/load_valid must be ignored.
    send(8'hA5);
    repeat (6) begin
      din        = W'($urandom);
      load_valid = 1'($urandom);
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    idle(12);

    // Randomized traffic.
    repeat (25) begin
      if ($urandom_range(0, 2) != 0) send(W'($urandom));
      else idle($urandom_range(1, 4));
    end
    idle(12);

    // Reset mid-frame, between clock edges.
    send(8'hA5);
    idle(3);
    #2;
    async_reset = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    async_reset = 1'b1;
    idle(12);

    // Load accepted on the first edge after reset release.
    send(8'h3C);
    idle(12);

    chk("drain_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock, LSB first. It is the transmit end of the team's serial shift-register link. Its frame format (sout_valid framing, LSB-first order) is the format the existing SIPO receivers consume. It is built from the same asynchronously-reset D flip-flop style used across the flip-flop library.

## Interface
- WIDTH, 8: data word width in bits; legal range 2–32.
- clk  input  1  rising-edge clock.
- async_reset  input  1  reset; asynchronous, active-low.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- load_valid  input  1  source has a word on din.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  high with the first bit of each frame.
- done  output  1  one-cycle pulse with the last bit of each frame.

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: data bits going out.
  - PARITY: parity bit going out; exists only with PISO_PARITY_EN.
- Internal state:
  - shift register sreg[WIDTH-1:0].
  - bit counter cnt, width $clog2(WIDTH+1).
  - parity accumulator par.
- Accept condition: a load is accepted when load_valid && load_ready at a rising clk edge.
- On accept:
  - sreg <= din, cnt <= 0, par <= ^din.
  - Next state is SHIFT.
- SHIFT, each cycle:
  - sout = sreg[0], sout_valid = 1.
  - At the edge: sreg shifts right by one, cnt increments.
  - When cnt == WIDTH-1, the next state is PARITY (macro defined) or IDLE.
  - If an accept happens on that same edge, the next state is SHIFT with the new word.
- PARITY, one cycle:
  - sout = par (even parity over data), sout_valid = 1.
  - Next state is IDLE, or SHIFT on a simultaneous accept.
- load_ready is combinational: high in IDLE and high during the final bit cycle of a frame; low otherwise. This gives gap-free back-to-back frames.
- IDLE outputs: sout = 0, sout_valid = 0, frame_start = 0, done = 0.
- frame_start = 1 on the first SHIFT cycle of a frame (cnt == 0).
- done = 1 on the final bit cycle (last data bit, or the parity bit when enabled).
- Changes to load_valid or din while load_ready is low are ignored; the word is never corrupted.

## Timing
- Reset asserted, at any time including mid-frame:
  - State goes to IDLE immediately (asynchronous). sreg = 0, cnt = 0, par = 0.
  - Outputs: sout = 0, sout_valid = 0, frame_start = 0, done = 0, load_ready = 1.
  - The aborted frame produces no done.
- Reset deassertion: a load can be accepted at the first rising edge after async_reset goes high.
- Latency: first bit appears on sout in the cycle after the accepting edge.
- Frame length: WIDTH cycles, or WIDTH+1 with parity; frames are contiguous, with no idle bits between them.
- Throughput:
  - One word per WIDTH cycles with continuous load_valid (WIDTH+1 with parity).
  - Without back-to-back loading, a new frame starts in the cycle after IDLE.
- All outputs except load_ready are registered or decoded from registered state only; there is no combinational path from din or load_valid to sout.

## Configuration
- Macro: PISO_PARITY_EN.
- Defined: an even-parity bit is appended after the MSB. done and the back-to-back load_ready move to the parity cycle, and the frame is WIDTH+1 cycles.
- Undefined: the PARITY state and par are not built, and the frame is exactly WIDTH cycles.

## Test plan
- Reset checks: assert async_reset low between clock edges, mid-frame, with WIDTH=8 and din=8'hA5 loaded. Required: outputs reach their reset values before the next edge, no done pulse, and load_ready = 1.
- Single frame (WIDTH=8, macro off): load 8'hA5 once. Required sout sequence is 1,0,1,0,0,1,0,1. sout_valid is high for exactly 8 cycles, frame_start is high on cycle 1, done is high on cycle 8.
- Back-to-back frames: hold load_valid high with 8'h0F then 8'hF0. Required: 16 contiguous valid cycles with sout = 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; load_ready pulses high only on cycles 8 and 16.
- Busy-time changes ignored: while busy, toggle din and load_valid every cycle. Required: the frame in flight is unchanged and no extra accept occurs.
- Parity frame (macro on): load 8'h07. Required: 1,1,1,0,0,0,0,0 followed by parity 1, 9 valid cycles, done on cycle 9. For 8'hA5 the parity bit is 0.
